sweep_controller: RTL and testbench
===================================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Parameter: TICKS_PER_MS, default 100000, clk cycles per 1 ms sweep step (range 2..2^20).
REQ-002 clk  in  1  system clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 freq_center  in  20  configured frequency in Hz (1..999999).
REQ-005 sweep_range  in  17  sweep half-span in Hz (0..50000).
REQ-006 sweep_speed  in  13  step in Hz per ms (0..4000).
REQ-007 sweep_mode  in  2  00 off, 01 sawtooth up, 10 sawtooth down, 11 triangle.
REQ-008 freq_cur  out  20  instantaneous frequency to the phase accumulator, registered.
REQ-009 sweep_active  out  1  high while state is UP or DOWN.
REQ-010 sweep_wrap  out  1  one-cycle pulse at every sawtooth wrap or triangle turnaround.

Function
REQ-011 States: IDLE, UP, DOWN; state, freq_cur, tick counter and mode_q all registered.
REQ-012 lo = (freq_center > sweep_range) ? freq_center - sweep_range : 1, computed 21-bit, combinational.
REQ-013 hi = min(freq_center + sweep_range, 999999), computed 21-bit, combinational.
REQ-014 Tick counter counts 0..TICKS_PER_MS-1 and wraps; ms_tick is high in the cycle the counter equals TICKS_PER_MS-1.
REQ-015 mode_q registers sweep_mode every cycle; restart is asserted in any cycle where sweep_mode != mode_q.
REQ-016 On restart: counter <= 0; mode 00 -> IDLE; 01 or 11 -> UP with freq_cur <= lo; 10 -> DOWN with freq_cur <= hi; sweep_wrap stays low.
REQ-017 IDLE: freq_cur <= freq_center every cycle, counter held at 0, sweep_active = 0.
REQ-018 UP on ms_tick: if freq_cur + sweep_speed < hi, then freq_cur <= freq_cur + sweep_speed.
REQ-019 UP on ms_tick with freq_cur + sweep_speed >= hi: mode 01 -> freq_cur <= lo and stay UP; mode 11 -> freq_cur <= hi and go to DOWN; sweep_wrap = 1 in both cases.
REQ-020 DOWN on ms_tick: if freq_cur > lo + sweep_speed, then freq_cur <= freq_cur - sweep_speed.
REQ-021 DOWN on ms_tick with freq_cur <= lo + sweep_speed: mode 10 -> freq_cur <= hi and stay DOWN; mode 11 -> freq_cur <= lo and go to UP; sweep_wrap = 1 in both cases.
REQ-022 sweep_speed = 0: freq_cur holds with no wrap, unless lo == hi, in which case REQ-019/021 apply and freq_cur stays at lo.
REQ-023 Outside ms_tick in UP/DOWN: if freq_cur > hi then freq_cur <= hi; if freq_cur < lo then freq_cur <= lo; state is unchanged and no sweep_wrap (handles center/range edits mid-sweep).
REQ-024 Priority, highest first: rst, restart, ms_tick step, clamp.
REQ-025 All sums and differences use 21-bit arithmetic; freq_cur never leaves 1..999999.
REQ-026 sweep_wrap is 0 in every cycle not covered by REQ-019/021.

Reset
REQ-027 On rst: state IDLE, freq_cur <= 0, counter <= 0, mode_q <= 00, sweep_active 0, sweep_wrap 0.
REQ-028 First cycle after rst: restart per REQ-015/016 if sweep_mode != 00; otherwise IDLE loads freq_center.
REQ-029 rst asserted mid-sweep takes effect on the next edge and overrides every other event in that cycle.

Verification (TICKS_PER_MS=4)
REQ-030 Mode 00, center 100000 -> freq_cur = 100000 from cycle 2 after reset; sweep_active 0; no wrap.
REQ-031 Center 100000, range 20000, speed 1000, mode 01 -> freq_cur starts at 80000, +1000 every 4 cycles; on the tick where 119000+1000 >= 120000, freq_cur = 80000 with a one-cycle wrap.
REQ-032 Same config, mode 11 -> 80000 up to 120000 (wrap), then down to 80000 (wrap), repeating; sweep_active stays 1.
REQ-033 Center 5000, range 20000, speed 4000, mode 10 -> lo = 1, hi = 25000; sequence 25000, 21000, ..., 5000, 1000, then 25000 with wrap.
REQ-034 Mid-UP at 110000, range changed to 5000 -> freq_cur = 105000 next cycle, no wrap; mode changed 01->10 -> freq_cur = hi and counter reset.
REQ-035 rst pulsed mid-triangle -> freq_cur 0, IDLE next cycle; mode 11 held -> restart at lo in UP on the following cycle.

Source files
------------

// File: rtl/sweep_controller.sv
// Frequency sweep controller: steps freq_cur once per millisecond between lo and hi
// in sawtooth-up, sawtooth-down or triangle fashion around freq_center.
module sweep_controller #(
   parameter int unsigned TICKS_PER_MS = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] freq_center,
   input  logic [16:0] sweep_range,
   input  logic [12:0] sweep_speed,
   input  logic [1:0]  sweep_mode,
   output logic [19:0] freq_cur,
   output logic        sweep_active,
   output logic        sweep_wrap
);

   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

   localparam int unsigned CW = $clog2(TICKS_PER_MS);
   localparam logic [20:0] F_MAX = 21'd999999;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [1:0]      mode_q;

   logic [20:0] center_w, range_w, speed_w, cur_w;
   logic [20:0] lo, hi, hi_raw, sum_w, lo_plus_w;
   logic        ms_tick, restart, hold_step;

   assign center_w  = {1'b0, freq_center};
   assign range_w   = {4'b0, sweep_range};
   assign speed_w   = {8'b0, sweep_speed};
   assign cur_w     = {1'b0, freq_cur};

   assign lo        = (center_w > range_w) ? center_w - range_w : 21'd1;
   assign hi_raw    = center_w + range_w;
   assign hi        = (hi_raw > F_MAX) ? F_MAX : hi_raw;
   assign sum_w     = cur_w + speed_w;
   assign lo_plus_w = lo + speed_w;

   assign ms_tick   = (cnt_reg == CW'(TICKS_PER_MS - 1));
   assign restart   = (sweep_mode != mode_q);
   // A zero step only forces wrap handling when the band has collapsed to one point.
   assign hold_step = (speed_w == 21'd0) && (lo != hi);

   assign sweep_active = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         freq_cur   <= 20'd0;
         cnt_reg    <= '0;
         mode_q     <= 2'b00;
         sweep_wrap <= 1'b0;
      end else begin
         mode_q     <= sweep_mode;
         sweep_wrap <= 1'b0;
         if (restart) begin
            cnt_reg <= '0;
            case (sweep_mode)
               2'b00: state_reg <= IDLE;
               2'b10: begin
                  state_reg <= DOWN;
                  freq_cur  <= hi[19:0];
               end
               default: begin
                  state_reg <= UP;
                  freq_cur  <= lo[19:0];
               end
            endcase
         end else if (state_reg == IDLE) begin
            freq_cur <= freq_center;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= ms_tick ? '0 : cnt_reg + CW'(1);
            if (ms_tick) begin
               if (hold_step) begin
                  freq_cur <= freq_cur;
               end else if (state_reg == UP) begin
                  if (sum_w < hi) begin
                     freq_cur <= sum_w[19:0];
                  end else begin
                     sweep_wrap <= 1'b1;
                     if (mode_q == 2'b11) begin
                        freq_cur  <= hi[19:0];
                        state_reg <= DOWN;
                     end else begin
                        freq_cur <= lo[19:0];
                     end
                  end
               end else begin
                  if (cur_w > lo_plus_w) begin
                     freq_cur <= freq_cur - sweep_speed;
                  end else begin
                     sweep_wrap <= 1'b1;
                     if (mode_q == 2'b11) begin
                        freq_cur  <= lo[19:0];
                        state_reg <= UP;
                     end else begin
                        freq_cur <= hi[19:0];
                     end
                  end
               end
            end else if (cur_w > hi) begin
               // Pull back inside the band after center/range edits mid-sweep.
               freq_cur <= hi[19:0];
            end else if (cur_w < lo) begin
               freq_cur <= lo[19:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller: a behavioural model predicts each cycle's
// outputs, a separate monitor compares them against the DUT.
module tb_sweep_controller;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] freq_center = 20'd100000;
   logic [16:0] sweep_range = 17'd0;
   logic [12:0] sweep_speed = 13'd0;
   logic [1:0]  sweep_mode  = 2'b00;
   logic [19:0] freq_cur;
   logic        sweep_active;
   logic        sweep_wrap;

   always #5 clk = ~clk;

   sweep_controller #(.TICKS_PER_MS(T)) dut (
      .clk          (clk),
      .rst          (rst),
      .freq_center  (freq_center),
      .sweep_range  (sweep_range),
      .sweep_speed  (sweep_speed),
      .sweep_mode   (sweep_mode),
      .freq_cur     (freq_cur),
      .sweep_active (sweep_active),
      .sweep_wrap   (sweep_wrap)
   );

   typedef struct {
      int f;
      bit a;
      bit w;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cycle  = 0;
   int   wraps_seen = 0;

   // stimulus configuration currently applied
   bit cfg_rst = 1'b1;
   int cfg_c = 100000, cfg_r = 0, cfg_s = 0, cfg_m = 0;

   // reference model: direction +1 rising, -1 falling, 0 parked at center
   int m_freq = 0, m_dir = 0, m_mq = 0, m_elapsed = 0;
   bit m_wrap = 1'b0;

   task automatic model_step();
      int lo, hi;
      bit tick;
      lo = (cfg_c > cfg_r) ? cfg_c - cfg_r : 1;
      hi = (cfg_c + cfg_r > 999999) ? 999999 : cfg_c + cfg_r;
      m_wrap = 1'b0;
      if (cfg_rst) begin
         m_freq = 0; m_dir = 0; m_mq = 0; m_elapsed = 0;
      end else if (cfg_m != m_mq) begin
         m_mq = cfg_m;
         m_elapsed = 0;
         if (cfg_m == 0) m_dir = 0;
         else if (cfg_m == 2) begin m_dir = -1; m_freq = hi; end
         else begin m_dir = 1; m_freq = lo; end
      end else if (m_dir == 0) begin
         m_freq = cfg_c;
      end else begin
         tick = ((m_elapsed % T) == T - 1);
         m_elapsed++;
         if (!tick) begin
            if (m_freq > hi) m_freq = hi;
            else if (m_freq < lo) m_freq = lo;
         end else if (cfg_s == 0 && lo != hi) begin
            m_freq = m_freq;
         end else if (m_dir > 0) begin
            if (m_freq + cfg_s < hi) m_freq += cfg_s;
            else begin
               m_wrap = 1'b1;
               if (m_mq == 3) begin m_freq = hi; m_dir = -1; end
               else m_freq = lo;
            end
         end else begin
            if (m_freq > lo + cfg_s) m_freq -= cfg_s;
            else begin
               m_wrap = 1'b1;
               if (m_mq == 3) begin m_freq = lo; m_dir = 1; end
               else m_freq = hi;
            end
         end
      end
   endtask

   task automatic drive_cycle();
      exp_t e;
      @(negedge clk);
      rst         = cfg_rst;
      freq_center = cfg_c[19:0];
      sweep_range = cfg_r[16:0];
      sweep_speed = cfg_s[12:0];
      sweep_mode  = cfg_m[1:0];
      model_step();
      e.f = m_freq;
      e.a = (m_dir != 0);
      e.w = m_wrap;
      sb.push_back(e);
   endtask

   task automatic run(input int n, input bit perturb);
      for (int i = 0; i < n; i++) begin
         if (perturb) begin
            if ($urandom_range(0, 149) == 0) cfg_r = $urandom_range(0, 50000);
            if ($urandom_range(0, 199) == 0) cfg_c = $urandom_range(1, 999999);
            if ($urandom_range(0, 249) == 0) cfg_m = $urandom_range(0, 3);
            if ($urandom_range(0, 99) == 0)  cfg_s = $urandom_range(0, 4000);
            cfg_rst = ($urandom_range(0, 399) == 0);
         end
         drive_cycle();
         cfg_rst = 1'b0;
      end
   endtask

   task automatic set_cfg(input int c, input int r, input int s, input int m);
      cfg_c = c; cfg_r = r; cfg_s = s; cfg_m = m;
   endtask

   // monitor: outputs are present every cycle, so one expectation per edge
   always @(posedge clk) begin
      exp_t e;
      #1;
      cycle++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks += 3;
         if (int'(freq_cur) != e.f) begin
            errors++;
            $display("FAIL freq_cur cycle %0d: got %0d expected %0d", cycle, freq_cur, e.f);
         end
         if (sweep_active !== e.a) begin
            errors++;
            $display("FAIL sweep_active cycle %0d: got %b expected %b", cycle, sweep_active, e.a);
         end
         if (sweep_wrap !== e.w) begin
            errors++;
            $display("FAIL sweep_wrap cycle %0d: got %b expected %b", cycle, sweep_wrap, e.w);
         end
         if (e.w) begin
            wraps_seen++;
            $display("wrap cycle %0d freq_cur=%0d active=%b", cycle, freq_cur, sweep_active);
         end
      end
   end

   initial begin
      int n;
      // reset, then parked at center
      cfg_rst = 1'b1; set_cfg(100000, 0, 0, 0);
      run(3, 1'b0);
      run(10, 1'b0);
      // sawtooth up 80000..120000
      set_cfg(100000, 20000, 1000, 1);
      run(400, 1'b0);
      // triangle, then reset mid-sweep with mode held
      cfg_m = 3;
      run(500, 1'b0);
      cfg_rst = 1'b1;
      run(1, 1'b0);
      run(20, 1'b0);
      // sawtooth down with lo clipped to 1
      set_cfg(5000, 20000, 4000, 0);
      run(2, 1'b0);
      cfg_m = 2;
      run(60, 1'b0);
      // range narrowed mid-up, then direction change
      set_cfg(100000, 20000, 1000, 0);
      run(2, 1'b0);
      cfg_m = 1;
      run(121, 1'b0);
      cfg_r = 5000;
      run(10, 1'b0);
      cfg_m = 2;
      run(20, 1'b0);
      // zero speed: collapsed band, then open band
      set_cfg(300000, 0, 0, 3);
      run(20, 1'b0);
      cfg_r = 100;
      run(20, 1'b0);
      // edges of the frequency range
      set_cfg(999999, 50000, 4000, 3);
      run(200, 1'b0);
      set_cfg(1, 50000, 3000, 1);
      run(200, 1'b0);
      // randomized segments with mid-segment edits and reset pulses
      for (int seg = 0; seg < 30; seg++) begin
         case ($urandom_range(0, 3))
            0: cfg_c = $urandom_range(1, 60000);
            1: cfg_c = $urandom_range(940000, 999999);
            default: cfg_c = $urandom_range(1, 999999);
         endcase
         cfg_r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50000) : $urandom_range(0, 8000);
         cfg_s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4000);
         cfg_m = $urandom_range(0, 3);
         n = $urandom_range(50, 400);
         run(n, 1'b1);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
